// File: rtl/ifetch_seq.sv
// ifetch_seq -- instruction fetch and sequencing unit.
//
// Owns the program counter and the instruction register. On a fetch_start
// pulse it requests the word at pc from instruction memory, waits up to
// ACK_TIMEOUT cycles for imem_ack, latches the returned word into instr and
// advances pc. While an instruction is held, a br_eval pulse resolves the
// conditional branches BRA/BRR/BNE/BNR against the status flags. Fetching a
// HLT (opcode 15) parks the unit until reset.
//
// Ports:
//   clk          system clock, rising edge
//   rst_f        synchronous reset, active-high
//   fetch_start  pulse: start fetching the instruction at pc
//   br_eval      pulse: resolve the branch held in instr
//   stat         status flags {C,N,V,Z}
//   imem_rdata   instruction memory read data, valid with imem_ack
//   imem_ack     instruction memory data-valid strobe
//   imem_req     instruction memory read request
//   imem_addr    instruction memory address
//   instr        instruction register
//   opcode       instr[31:28]
//   mm           instr[27:24] (branch condition mask)
//   instr_valid  instr holds a freshly fetched instruction
//   pc           program counter
//   br_taken     one-cycle pulse when a branch rewrites pc
//   halt         sticky: a HLT was fetched
//   fetch_err    sticky: imem_ack did not arrive in time
module ifetch_seq #(
  parameter int AW          = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          fetch_start,
  input  logic          br_eval,
  input  logic [3:0]    stat,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_ack,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   instr,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          br_taken,
  output logic          halt,
  output logic          fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  // The timeout fires on the ACK_TIMEOUT-th consecutive REQ cycle without ack.
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  localparam logic [3:0] OP_BRA = 4'd4;
  localparam logic [3:0] OP_BRR = 4'd5;
  localparam logic [3:0] OP_BNE = 4'd6;
  localparam logic [3:0] OP_BNR = 4'd7;
  localparam logic [3:0] OP_HLT = 4'd15;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [AW-1:0]   pc_n, addr_n;
  logic [31:0]     instr_n;
  logic            vld_n, req_n, brt_n, halt_n, err_n;

  logic [AW-1:0]   imm;
  logic            hit;
  logic            br_take;
  logic [AW-1:0]   br_target;
  logic [AW-1:0]   pc_post;

  assign opcode = instr[31:28];
  assign mm     = instr[27:24];

  // pc already points past the branch, so relative targets are pc + imm.
  assign imm = AW'(instr[15:0]);
  assign hit = |(stat & mm);

  always_comb begin
    br_take   = 1'b0;
    br_target = pc;
    case (opcode)
      OP_BRA: begin br_take = hit;  br_target = imm;      end
      OP_BRR: begin br_take = hit;  br_target = pc + imm; end
      OP_BNE: begin br_take = !hit; br_target = imm;      end
      OP_BNR: begin br_take = !hit; br_target = pc + imm; end
      default: begin br_take = 1'b0; br_target = pc;      end
    endcase
  end

  // A fetch issued in the same cycle as a branch goes to the resolved target.
  assign pc_post = (br_eval && br_take) ? br_target : pc;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_n    = pc;
    addr_n  = imem_addr;
    instr_n = instr;
    vld_n   = instr_valid;
    req_n   = imem_req;
    brt_n   = 1'b0;
    halt_n  = halt;
    err_n   = fetch_err;

    case (state)
      IDLE: begin
        if (fetch_start) begin
          addr_n  = pc;
          req_n   = 1'b1;
          cnt_n   = '0;
          state_n = REQ;
        end
      end

      REQ: begin
        if (imem_ack) begin
          instr_n = imem_rdata;
          vld_n   = 1'b1;
          req_n   = 1'b0;
          pc_n    = pc + AW'(1);
          if (imem_rdata[31:28] == OP_HLT) begin
            halt_n  = 1'b1;
            state_n = STOP;
          end else begin
            state_n = HOLD;
          end
        end else if (cnt == CNT_LAST) begin
          err_n   = 1'b1;
          req_n   = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      HOLD: begin
        if (br_eval && br_take) begin
          pc_n  = br_target;
          brt_n = 1'b1;
        end
        if (fetch_start) begin
          vld_n   = 1'b0;
          req_n   = 1'b1;
          addr_n  = pc_post;
          cnt_n   = '0;
          state_n = REQ;
        end
      end

      STOP: begin
        req_n = 1'b0;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state       <= IDLE;
      cnt         <= '0;
      pc          <= '0;
      imem_addr   <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      br_taken    <= 1'b0;
      halt        <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pc          <= pc_n;
      imem_addr   <= addr_n;
      instr       <= instr_n;
      instr_valid <= vld_n;
      imem_req    <= req_n;
      br_taken    <= brt_n;
      halt        <= halt_n;
      fetch_err   <= err_n;
    end
  end

endmodule
